apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Single-master AMBA APB (APB4-style) bridge. It converts a simple request interface (Transfer/IN_ADDR/IN_DATA/IN_WRITE/IN_STRB) into APB SETUP/ACCESS bus cycles toward SLAVES_NUM slaves, with one-hot PSEL address decode. It returns read data and slave error to the requester. It sits between the system-side requester and APB peripherals such as the GPIO and UART slaves.

Parameters:
DATA_WIDTH, 32, width of IN_DATA/PWDATA/PRDATA/OUT_RDATA
ADDRESS_WIDTH, 4, width of IN_ADDR/PADDR
STRB_WIDTH, 4, byte-strobe width (DATA_WIDTH/8)
SLAVES_NUM, 2, number of slaves, i.e. PSEL width

Ports:
PCLK  in  1  bus clock, rising edge
PRESETn  in  1  reset; one clock; reset is asynchronous and active-high (asserted when 1, despite the name)
Transfer  in  1  request pending
IN_ADDR  in  ADDRESS_WIDTH  request address
IN_DATA  in  DATA_WIDTH  write data
IN_WRITE  in  1  1=write, 0=read
IN_STRB  in  STRB_WIDTH  write byte strobes
PRDATA  in  DATA_WIDTH  muxed slave read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error
PADDR  out  ADDRESS_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PWRITE  out  1  APB direction
PSTRB  out  STRB_WIDTH  APB strobes
PSEL  out  SLAVES_NUM  one-hot slave select
PENABLE  out  1  ACCESS-phase flag
OUT_RDATA  out  DATA_WIDTH  captured read data
OUT_SLVERR  out  1  captured slave error

Behaviour:
- Reset (PRESETn=1, asynchronous): state IDLE; all outputs 0.
- FSM states are IDLE, SETUP and ACCESS; all transitions occur on the PCLK rising edge.
- IDLE: Transfer=1 -> SETUP, else stay.
- SETUP: always -> ACCESS after exactly one cycle.
- ACCESS: PREADY=0 -> stay (wait state). PREADY=1 and Transfer=1 -> SETUP (back-to-back transfer, no IDLE cycle). PREADY=1 and Transfer=0 -> IDLE.
- Request latch: on every edge entering SETUP, register PADDR<=IN_ADDR, PWDATA<=IN_DATA, PWRITE<=IN_WRITE, and PSTRB<=IN_STRB on writes or 0 on reads. These outputs are held stable through SETUP and all ACCESS wait cycles. Requester changes during ACCESS do not disturb the current transfer.
- Decode: slave index = top ceil(log2(SLAVES_NUM)) bits of IN_ADDR. For defaults this is IN_ADDR[3]: 1 -> PSEL=2'b10, 0 -> PSEL=2'b01.
  - PSEL is registered with the request latch and held in SETUP and ACCESS.
  - PSEL is 0 in IDLE.
  - An index >= SLAVES_NUM gives PSEL=0, and the transfer still completes on PREADY.
- PENABLE=1 only in ACCESS; it is 0 in IDLE and SETUP.
- Completion is ACCESS with PREADY=1 at the edge.
  - Read: OUT_RDATA<=PRDATA.
  - Both directions: OUT_SLVERR<=PSLVERR.
  - OUT_RDATA holds until the next read completion.
  - OUT_SLVERR holds until the next completion.
- PRDATA, PREADY and PSLVERR are ignored outside ACCESS.
- Minimum transfer is 2 cycles; each wait cycle adds 1.
- Reset asserted mid-transfer aborts immediately to IDLE with outputs 0.

Decomposition:
- Shared package apb_pkg: state enum (IDLE, SETUP, ACCESS) and default width constants.
- One natural sub-module: apb_addr_decoder, which maps the address to one-hot PSEL from SLAVES_NUM and ADDRESS_WIDTH.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Write, no wait: Transfer=1, IN_ADDR=4'hF, IN_DATA=240, IN_WRITE=1, PREADY=1 in ACCESS. Expect SETUP PSEL=2'b10, PADDR=4'hF, PWDATA=240, PENABLE=0; next cycle PENABLE=1; then a back-to-back second write (addr 4'h1, data 15) gives PSEL=2'b01; with Transfer=0 return to IDLE, PENABLE=0, PSEL=0.
- Write with waits: same as above but PREADY=0 for 2 ACCESS cycles. PENABLE stays 1, PADDR/PWDATA stay 4'hF/240 even though IN_ADDR changes to 4'h1; completes one cycle after PREADY=1.
- Read: IN_WRITE=0, addr 4'hF, PRDATA=240 with PREADY=1 -> OUT_RDATA=240, PSTRB=0. Then addr 4'h1, PRDATA=15 -> OUT_RDATA=15, PSEL=2'b01.
- Read with waits plus error: 3 wait cycles, then PREADY=1 with PSLVERR=1 -> OUT_SLVERR=1; OUT_RDATA updates only at completion.
- Reset: assert PRESETn=1 during ACCESS -> immediately IDLE, all outputs 0; after deassert with Transfer=0, stays IDLE.
- Strobes: write with IN_STRB=4'b0101 -> PSTRB=4'b0101; a following read -> PSTRB=0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: the bus-phase state type,
// default widths and the decode-width helper.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_DATA_WIDTH    = 32;
   localparam int DEF_ADDRESS_WIDTH = 4;
   localparam int DEF_STRB_WIDTH    = 4;
   localparam int DEF_SLAVES_NUM    = 2;

   // A single slave needs no select bits.
   function automatic int sel_bits(input int slaves);
      return (slaves > 1) ? $clog2(slaves) : 0;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Address-to-PSEL decoder: the top sel_bits(SLAVES_NUM) address bits pick the
// slave; an index with no slave behind it yields an all-zero select.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int SLAVES_NUM    = DEF_SLAVES_NUM
) (
   input  logic [ADDRESS_WIDTH-1:0] addr,
   output logic [SLAVES_NUM-1:0]    sel
);

   localparam int SEL_W = sel_bits(SLAVES_NUM);

   logic [ADDRESS_WIDTH-1:0] idx_s;

   // Shifting the full address keeps the index aligned to the top bits for any width.
   assign idx_s = addr >> (ADDRESS_WIDTH - SEL_W);

   // One select line per slave, set only on an exact index match.
   always_comb begin
      sel = '0;
      for (int i = 0; i < SLAVES_NUM; i++) begin
         sel[i] = (idx_s == ADDRESS_WIDTH'(i));
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4-style single-master bridge: turns a Transfer request into SETUP/ACCESS
// bus cycles and returns read data and slave error to the requester.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int STRB_WIDTH    = DEF_STRB_WIDTH,
   parameter int SLAVES_NUM    = DEF_SLAVES_NUM
) (
   input  logic                     PCLK,
   input  logic                     PRESETn,
   input  logic                     Transfer,
   input  logic [ADDRESS_WIDTH-1:0] IN_ADDR,
   input  logic [DATA_WIDTH-1:0]    IN_DATA,
   input  logic                     IN_WRITE,
   input  logic [STRB_WIDTH-1:0]    IN_STRB,
   input  logic [DATA_WIDTH-1:0]    PRDATA,
   input  logic                     PREADY,
   input  logic                     PSLVERR,
   output logic [ADDRESS_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0]    PWDATA,
   output logic                     PWRITE,
   output logic [STRB_WIDTH-1:0]    PSTRB,
   output logic [SLAVES_NUM-1:0]    PSEL,
   output logic                     PENABLE,
   output logic [DATA_WIDTH-1:0]    OUT_RDATA,
   output logic                     OUT_SLVERR
);

   apb_state_e               state_r;
   logic [SLAVES_NUM-1:0]    sel_s;
   logic [STRB_WIDTH-1:0]    strb_s;

   apb_addr_decoder #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .SLAVES_NUM    (SLAVES_NUM)
   ) u_decoder (
      .addr (IN_ADDR),
      .sel  (sel_s)
   );

   // Reads never drive byte strobes onto the bus.
   assign strb_s = IN_WRITE ? IN_STRB : '0;

   // Bus-phase FSM; every APB output is registered here. The request is
   // latched only on edges entering SETUP, so requester activity in ACCESS is ignored.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         state_r    <= IDLE;
         PADDR      <= '0;
         PWDATA     <= '0;
         PWRITE     <= 1'b0;
         PSTRB      <= '0;
         PSEL       <= '0;
         PENABLE    <= 1'b0;
         OUT_RDATA  <= '0;
         OUT_SLVERR <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               PENABLE <= 1'b0;
               if (Transfer) begin
                  state_r <= SETUP;
                  PADDR   <= IN_ADDR;
                  PWDATA  <= IN_DATA;
                  PWRITE  <= IN_WRITE;
                  PSTRB   <= strb_s;
                  PSEL    <= sel_s;
               end else begin
                  state_r <= IDLE;
                  PSEL    <= '0;
               end
            end
            SETUP: begin
               state_r <= ACCESS;
               PENABLE <= 1'b1;
            end
            ACCESS: begin
               if (PREADY) begin
                  OUT_SLVERR <= PSLVERR;
                  if (!PWRITE) begin
                     OUT_RDATA <= PRDATA;
                  end else begin
                     OUT_RDATA <= OUT_RDATA;
                  end
                  PENABLE <= 1'b0;
                  // Back-to-back: go straight to SETUP with the next request.
                  if (Transfer) begin
                     state_r <= SETUP;
                     PADDR   <= IN_ADDR;
                     PWDATA  <= IN_DATA;
                     PWRITE  <= IN_WRITE;
                     PSTRB   <= strb_s;
                     PSEL    <= sel_s;
                  end else begin
                     state_r <= IDLE;
                     PSEL    <= '0;
                  end
               end else begin
                  state_r <= ACCESS;
                  PENABLE <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               PSEL    <= '0;
               PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised and directed bench for apb_master_bridge against a transaction-level
// reference model; a second 3-slave instance covers the unmapped-index decode.
module tb_apb_master_bridge;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        Transfer;
   logic [3:0]  IN_ADDR;
   logic [31:0] IN_DATA;
   logic        IN_WRITE;
   logic [3:0]  IN_STRB;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;
   logic [3:0]  PADDR;
   logic [31:0] PWDATA;
   logic        PWRITE;
   logic [3:0]  PSTRB;
   logic [1:0]  PSEL;
   logic        PENABLE;
   logic [31:0] OUT_RDATA;
   logic        OUT_SLVERR;

   logic [3:0]  p3_paddr;
   logic [31:0] p3_pwdata;
   logic        p3_pwrite;
   logic [3:0]  p3_pstrb;
   logic [2:0]  p3_psel;
   logic        p3_penable;
   logic [31:0] p3_rdata;
   logic        p3_slverr;

   int checks = 0;
   int errors = 0;

   // Reference model state and the request list for one burst.
   logic [31:0] exp_rdata;
   logic        exp_err;
   logic [3:0]  req_addr  [8];
   logic [31:0] req_data  [8];
   logic        req_write [8];
   logic [3:0]  req_strb  [8];
   int          req_waits [8];
   logic [31:0] req_rdata [8];
   logic        req_err   [8];

   always #5 PCLK = ~PCLK;

   apb_master_bridge dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .Transfer(Transfer), .IN_ADDR(IN_ADDR),
      .IN_DATA(IN_DATA), .IN_WRITE(IN_WRITE), .IN_STRB(IN_STRB), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE),
      .OUT_RDATA(OUT_RDATA), .OUT_SLVERR(OUT_SLVERR)
   );

   apb_master_bridge #(.SLAVES_NUM(3)) dut3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .Transfer(Transfer), .IN_ADDR(IN_ADDR),
      .IN_DATA(IN_DATA), .IN_WRITE(IN_WRITE), .IN_STRB(IN_STRB), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PADDR(p3_paddr), .PWDATA(p3_pwdata),
      .PWRITE(p3_pwrite), .PSTRB(p3_pstrb), .PSEL(p3_psel), .PENABLE(p3_penable),
      .OUT_RDATA(p3_rdata), .OUT_SLVERR(p3_slverr)
   );

   // Slave index is the top ceil(log2(n)) address bits; no slave there means no select.
   function automatic int exp_psel(input logic [3:0] addr, input int n);
      int idx;
      idx = int'(addr) >> (4 - $clog2(n));
      return (idx < n) ? (1 << idx) : 0;
   endfunction

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic load_req(input int k);
      Transfer = 1'b1;
      IN_ADDR  = req_addr[k];
      IN_DATA  = req_data[k];
      IN_WRITE = req_write[k];
      IN_STRB  = req_strb[k];
   endtask

   task automatic scramble_inputs();
      Transfer = 1'($urandom);
      IN_ADDR  = 4'($urandom);
      IN_DATA  = $urandom;
      IN_WRITE = 1'($urandom);
      IN_STRB  = 4'($urandom);
      PRDATA   = $urandom;
      PSLVERR  = 1'($urandom);
   endtask

   task automatic randomize_req(input int k);
      req_addr[k]  = 4'($urandom);
      req_data[k]  = $urandom;
      req_write[k] = 1'($urandom);
      req_strb[k]  = 4'($urandom);
      req_waits[k] = int'($urandom_range(0, 3));
      req_rdata[k] = $urandom;
      req_err[k]   = 1'($urandom);
   endtask

   task automatic set_req(input int k, input logic [3:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] s, input int waits,
                          input logic [31:0] rd, input logic err);
      req_addr[k] = a;  req_data[k] = d;   req_write[k] = w;  req_strb[k] = s;
      req_waits[k] = waits; req_rdata[k] = rd; req_err[k] = err;
   endtask

   // Runs n back-to-back transfers from IDLE and checks every bus phase.
   task automatic run_seq(input int n);
      logic [40:0] exp_req;
      load_req(0);
      PREADY = 1'b0;
      tick();
      for (int k = 0; k < n; k++) begin
         exp_req = {req_addr[k], req_data[k], req_write[k],
                    (req_write[k] ? req_strb[k] : 4'b0000)};
         checks++;
         if ({PADDR, PWDATA, PWRITE, PSTRB} !== exp_req || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL setup_req[%0d]: got %h en=%b expected %h en=0", k,
                     {PADDR, PWDATA, PWRITE, PSTRB}, PENABLE, exp_req);
         end
         checks++;
         if (PSEL !== 2'(exp_psel(req_addr[k], 2)) || p3_psel !== 3'(exp_psel(req_addr[k], 3))) begin
            errors++;
            $display("FAIL setup_psel[%0d]: got %b/%b expected %b/%b", k, PSEL, p3_psel,
                     2'(exp_psel(req_addr[k], 2)), 3'(exp_psel(req_addr[k], 3)));
         end
         scramble_inputs();
         PREADY = 1'($urandom);
         tick();
         for (int w = 0; w <= req_waits[k]; w++) begin
            checks++;
            if (PENABLE !== 1'b1 || p3_penable !== 1'b1 ||
                {PADDR, PWDATA, PWRITE, PSTRB} !== exp_req ||
                PSEL !== 2'(exp_psel(req_addr[k], 2))) begin
               errors++;
               $display("FAIL access_hold[%0d.%0d]: got en=%b req=%h psel=%b expected en=1 req=%h",
                        k, w, PENABLE, {PADDR, PWDATA, PWRITE, PSTRB}, PSEL, exp_req);
            end
            checks++;
            if (OUT_RDATA !== exp_rdata || OUT_SLVERR !== exp_err) begin
               errors++;
               $display("FAIL access_out[%0d.%0d]: got %h/%b expected %h/%b", k, w,
                        OUT_RDATA, OUT_SLVERR, exp_rdata, exp_err);
            end
            if (w < req_waits[k]) begin
               scramble_inputs();
               PREADY = 1'b0;
               tick();
            end
         end
         PREADY  = 1'b1;
         PRDATA  = req_rdata[k];
         PSLVERR = req_err[k];
         if (k < n - 1) load_req(k + 1);
         else Transfer = 1'b0;
         tick();
         if (!req_write[k]) exp_rdata = req_rdata[k];
         exp_err = req_err[k];
         PREADY = 1'b0;
         checks++;
         if (OUT_RDATA !== exp_rdata || OUT_SLVERR !== exp_err ||
             p3_rdata !== exp_rdata || p3_slverr !== exp_err) begin
            errors++;
            $display("FAIL complete[%0d]: got %h/%b (3-slave %h/%b) expected %h/%b", k,
                     OUT_RDATA, OUT_SLVERR, p3_rdata, p3_slverr, exp_rdata, exp_err);
         end
      end
      checks++;
      if (PSEL !== 2'b00 || PENABLE !== 1'b0 || p3_psel !== 3'b000 || p3_penable !== 1'b0) begin
         errors++;
         $display("FAIL idle_after: got psel=%b en=%b psel3=%b en3=%b expected all 0",
                  PSEL, PENABLE, p3_psel, p3_penable);
      end
   endtask

   task automatic test_reset();
      PRESETn = 1'b1; Transfer = 1'b0; IN_ADDR = 4'h0; IN_DATA = 32'h0;
      IN_WRITE = 1'b0; IN_STRB = 4'h0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
      tick(); tick();
      checks++;
      if ({PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE, OUT_RDATA, OUT_SLVERR} !== 77'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE, OUT_RDATA, OUT_SLVERR});
      end
      PRESETn = 1'b0;
      exp_rdata = 32'h0;
      exp_err = 1'b0;
      tick(); tick();
      checks++;
      if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: got psel=%b en=%b expected 0/0", PSEL, PENABLE);
      end
   endtask

   task automatic test_write_no_wait();
      set_req(0, 4'hF, 32'd240, 1'b1, 4'hF, 0, 32'h0, 1'b0);
      set_req(1, 4'h1, 32'd15,  1'b1, 4'h3, 0, 32'h0, 1'b0);
      run_seq(2);
   endtask

   task automatic test_write_waits();
      set_req(0, 4'hF, 32'd240, 1'b1, 4'hF, 2, 32'h0, 1'b0);
      run_seq(1);
   endtask

   task automatic test_read();
      set_req(0, 4'hF, 32'h0, 1'b0, 4'hF, 0, 32'd240, 1'b0);
      set_req(1, 4'h1, 32'h0, 1'b0, 4'hF, 0, 32'd15,  1'b0);
      run_seq(2);
   endtask

   task automatic test_read_err();
      set_req(0, 4'h9, 32'h0, 1'b0, 4'h0, 3, 32'hCAFE_F00D, 1'b1);
      run_seq(1);
   endtask

   task automatic test_strobes();
      set_req(0, 4'h4, 32'h1234_5678, 1'b1, 4'b0101, 1, 32'h0, 1'b0);
      set_req(1, 4'hC, 32'h0, 1'b0, 4'b0101, 0, 32'h0BAD_BEEF, 1'b0);
      run_seq(2);
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 25; it++) begin
         n = int'($urandom_range(1, 5));
         for (int k = 0; k < n; k++) randomize_req(k);
         run_seq(n);
         if ($urandom_range(0, 1) == 1) tick();
      end
   endtask

   task automatic test_reset_mid();
      set_req(0, 4'hA, 32'h5555_AAAA, 1'b1, 4'hF, 0, 32'h0, 1'b0);
      load_req(0);
      PREADY = 1'b0;
      tick();
      tick();
      #2;
      PRESETn = 1'b1;
      #1;
      exp_rdata = 32'h0;
      exp_err = 1'b0;
      checks++;
      if ({PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE, OUT_RDATA, OUT_SLVERR} !== 77'h0) begin
         errors++;
         $display("FAIL reset_mid: got %h expected 0",
                  {PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE, OUT_RDATA, OUT_SLVERR});
      end
      Transfer = 1'b0;
      tick();
      PRESETn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle[%0d]: got psel=%b en=%b expected 0/0", i, PSEL, PENABLE);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_no_wait();
      test_write_waits();
      test_read();
      test_read_err();
      test_strobes();
      test_random();
      test_reset_mid();
      test_write_no_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
